// File: rtl/seg7_pkg.sv
// Shared constants, mode encoding and the hex font for the multiplexed
// 7-segment scanner. Segments are {dp,g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF       = 8'hFF;
  localparam int         DP_BIT        = 7;
  localparam logic [7:0] BLANK_PATTERN = SEG_OFF;

  typedef enum logic {
    MODE_HEX = 1'b0,
    MODE_RAW = 1'b1
  } disp_mode_e;

  // Common-anode glyphs for 0-F with the decimal point dark.
  function automatic logic [7:0] hex_font(input logic [3:0] nibble);
    hex_font = SEG_OFF;
    case (nibble)
      4'h0: hex_font = 8'hC0;
      4'h1: hex_font = 8'hF9;
      4'h2: hex_font = 8'hA4;
      4'h3: hex_font = 8'hB0;
      4'h4: hex_font = 8'h99;
      4'h5: hex_font = 8'h92;
      4'h6: hex_font = 8'h82;
      4'h7: hex_font = 8'hF8;
      4'h8: hex_font = 8'h80;
      4'h9: hex_font = 8'h90;
      4'hA: hex_font = 8'h88;
      4'hB: hex_font = 8'h83;
      4'hC: hex_font = 8'hC6;
      4'hD: hex_font = 8'hA1;
      4'hE: hex_font = 8'h86;
      4'hF: hex_font = 8'h8E;
      default: hex_font = SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/seg7_hex_font.sv
// Combinational nibble-to-glyph decoder for the scanner's hex text mode.
module seg7_hex_font
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = hex_font(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner: hex or raw segments, per-digit
// dp/blank/blink, leading-zero suppression, PWM brightness, tear-free updates.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int SCAN_DIV = 32768,
  parameter int PWM_W    = 4,
  parameter int BLINK_W  = 24
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  disp_mode,
  input  logic [8*N_DIGITS-1:0] i_data,
  input  logic [N_DIGITS-1:0]   i_dp,
  input  logic [N_DIGITS-1:0]   i_blank_mask,
  input  logic [N_DIGITS-1:0]   i_blink_mask,
  input  logic                  i_lzs,
  input  logic [PWM_W-1:0]      i_bright,
  input  logic                  i_load,
  output logic                  o_frame,
  output logic [7:0]            disp_seg_o,
  output logic [N_DIGITS-1:0]   disp_an_o
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0]   div_cnt;
  logic [IDX_W-1:0]   idx;
  logic [PWM_W-1:0]   pwm_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               tick;
  logic               wrap;

  // Pending set (written by i_load) and active set (what is on the pins).
  disp_mode_e            pend_mode,  act_mode;
  logic [8*N_DIGITS-1:0] pend_data,  act_data;
  logic [N_DIGITS-1:0]   pend_dp,    act_dp;
  logic [N_DIGITS-1:0]   pend_blank, act_blank;
  logic [N_DIGITS-1:0]   pend_blink, act_blink;
  logic                  pend_lzs,   act_lzs;
  logic                  pend_flag;
  logic                  act_valid;

  logic [3:0]          nibble;
  logic [7:0]          font_seg;
  logic [7:0]          hex_seg;
  logic [7:0]          src_seg;
  logic [N_DIGITS-1:0] nz_from;
  logic                lz_dark;
  logic                dark;

  assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign wrap = tick && (idx == IDX_W'(N_DIGITS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt   <= '0;
      idx       <= '0;
      pwm_cnt   <= '0;
      blink_cnt <= '0;
    end else begin
      div_cnt   <= tick ? '0 : div_cnt + DIV_W'(1);
      pwm_cnt   <= pwm_cnt + PWM_W'(1);
      blink_cnt <= blink_cnt + BLINK_W'(1);
      if (tick) begin
        idx <= wrap ? '0 : idx + IDX_W'(1);
      end
    end
  end

  // NOTE: the shadow sets carry an async reset so that a reset also discards a
  // load still waiting for the frame boundary.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_mode  <= MODE_HEX;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_blink <= '0;
      pend_lzs   <= 1'b0;
      pend_flag  <= 1'b0;
      act_mode   <= MODE_HEX;
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      act_blink  <= '0;
      act_lzs    <= 1'b0;
      act_valid  <= 1'b0;
    end else begin
      // A load on the wrap tick lands in pending only; the old pending (if
      // any) still goes live on this wrap.
      if (wrap && pend_flag) begin
        act_mode  <= pend_mode;
        act_data  <= pend_data;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
        act_blink <= pend_blink;
        act_lzs   <= pend_lzs;
        act_valid <= 1'b1;
      end
      if (i_load) begin
        pend_mode  <= disp_mode_e'(disp_mode);
        pend_data  <= i_data;
        pend_dp    <= i_dp;
        pend_blank <= i_blank_mask;
        pend_blink <= i_blink_mask;
        pend_lzs   <= i_lzs;
        pend_flag  <= 1'b1;
      end else if (wrap) begin
        pend_flag <= 1'b0;
      end
    end
  end

  // nz_from[k] is set when any nibble at position k or above is non-zero.
  always_comb begin
    logic acc;
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned (no latch), and blocking '=' lets acc ripple within the loop.
    acc     = 1'b0;
    nz_from = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      acc        = acc | (|act_data[4*k +: 4]);
      nz_from[k] = acc;
    end
  end

  assign nibble = act_data[4*idx +: 4];

  seg7_hex_font u_font (
    .nibble (nibble),
    .seg    (font_seg)
  );

  always_comb begin
    hex_seg         = font_seg;
    hex_seg[DP_BIT] = ~act_dp[idx];
    src_seg         = (act_mode == MODE_RAW) ? act_data[8*idx +: 8] : hex_seg;
    lz_dark         = act_lzs && (act_mode == MODE_HEX) && (idx != '0) && !nz_from[idx];
    dark            = !act_valid
                   || act_blank[idx]
                   || (act_blink[idx] && blink_cnt[BLINK_W-1])
                   || lz_dark
                   || (pwm_cnt >= i_bright);
  end

  // Segments and anode are registered together from the same index, so the
  // pins never show a new anode with stale segments.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      disp_seg_o <= BLANK_PATTERN;
      disp_an_o  <= '1;
      o_frame    <= 1'b0;
    end else begin
      o_frame <= wrap;
      if (dark) begin
        disp_seg_o <= BLANK_PATTERN;
        disp_an_o  <= '1;
      end else begin
        disp_seg_o <= src_seg;
        disp_an_o  <= ~(N_DIGITS'(1) << idx);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: a cycle-count based reference model
// plus directed scenario checks and a randomized run.
module tb_seg7_scan_ctrl;

  localparam int N     = 5;
  localparam int S     = 20;
  localparam int P     = 4;
  localparam int B     = 8;
  localparam int FRAME = N * S;
  localparam logic [7:0] FONT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                       8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic           clk = 1'b0;
  logic           rstn = 1'b1;
  logic           disp_mode;
  logic [8*N-1:0] i_data;
  logic [N-1:0]   i_dp, i_blank_mask, i_blink_mask;
  logic           i_lzs;
  logic [P-1:0]   i_bright;
  logic           i_load;
  logic           o_frame;
  logic [7:0]     disp_seg_o;
  logic [N-1:0]   disp_an_o;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.N_DIGITS(N), .SCAN_DIV(S), .PWM_W(P), .BLINK_W(B)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .disp_mode    (disp_mode),
    .i_data       (i_data),
    .i_dp         (i_dp),
    .i_blank_mask (i_blank_mask),
    .i_blink_mask (i_blink_mask),
    .i_lzs        (i_lzs),
    .i_bright     (i_bright),
    .i_load       (i_load),
    .o_frame      (o_frame),
    .disp_seg_o   (disp_seg_o),
    .disp_an_o    (disp_an_o)
  );

  typedef struct packed {
    logic           mode;
    logic [8*N-1:0] data;
    logic [N-1:0]   dp;
    logic [N-1:0]   blank;
    logic [N-1:0]   blink;
    logic           lzs;
  } shadow_t;

  shadow_t      m_pend, m_act;
  bit           m_pend_flag, m_valid;
  int           cyc;
  logic [7:0]   exp_seg;
  logic [N-1:0] exp_an;
  logic         exp_frame;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic model_reset();
    m_pend = '0; m_act = '0; m_pend_flag = 0; m_valid = 0; cyc = 0;
    exp_seg = 8'hFF; exp_an = '1; exp_frame = 1'b0;
  endtask

  // Advance one clock: the pins after edge cyc+1 follow the state after cyc edges.
  task automatic step();
    int idx, pwm;
    bit bmsb, wrap, dark;
    logic [7:0] src;
    logic [4*N-1:0] hexbits;
    idx     = (cyc / S) % N;
    pwm     = cyc % (1 << P);
    bmsb    = (cyc % (1 << B)) >= (1 << (B - 1));
    wrap    = (cyc % FRAME) == FRAME - 1;
    hexbits = m_act.data[4*N-1:0];
    if (m_act.mode) src = m_act.data[8*idx +: 8];
    else begin
      src = FONT[hexbits[4*idx +: 4]];
      if (m_act.dp[idx]) src[7] = 1'b0;
    end
    dark = !m_valid || m_act.blank[idx] || (m_act.blink[idx] && bmsb) || (pwm >= int'(i_bright))
        || (!m_act.mode && m_act.lzs && idx != 0 && (hexbits >> (4*idx)) == 0);
    if (wrap && m_pend_flag) begin m_act = m_pend; m_valid = 1; end
    if (i_load) begin
      m_pend = {disp_mode, i_data, i_dp, i_blank_mask, i_blink_mask, i_lzs};
      m_pend_flag = 1;
    end else if (wrap) m_pend_flag = 0;
    @(posedge clk); #1;
    cyc++;
    exp_seg   = dark ? 8'hFF : src;
    exp_an    = dark ? '1 : ~(N'(1) << idx);
    exp_frame = wrap;
  endtask

  task automatic load(input logic mode, input logic [8*N-1:0] data, input logic [N-1:0] dp,
                      input logic [N-1:0] blank, input logic [N-1:0] blink, input logic lzs);
    disp_mode = mode; i_data = data; i_dp = dp; i_blank_mask = blank;
    i_blink_mask = blink; i_lzs = lzs; i_load = 1'b1;
    step();
    i_load = 1'b0;
  endtask

  task automatic test_reset();
    disp_mode = 0; i_data = '0; i_dp = '0; i_blank_mask = '0; i_blink_mask = '0;
    i_lzs = 0; i_bright = '1; i_load = 0;
    #1 rstn = 1'b0;
    #1;
    n_checks++;
    if ({disp_seg_o, disp_an_o, o_frame} !== {8'hFF, {N{1'b1}}, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: seg=%h an=%b frame=%b, expected seg=ff an=%b frame=0",
               disp_seg_o, disp_an_o, o_frame, {N{1'b1}});
    end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      n_checks++;
      if ({disp_seg_o, disp_an_o, o_frame} !== {exp_seg, exp_an, exp_frame} ||
          disp_an_o !== '1 || disp_seg_o !== 8'hFF) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d: seg=%h an=%b frame=%b, expected seg=%h an=%b frame=%b",
                 cyc, disp_seg_o, disp_an_o, o_frame, 8'hFF, {N{1'b1}}, exp_frame);
      end
    end
  endtask

  task automatic test_hex_lzs();
    logic [7:0] want;
    for (int pass = 0; pass < 2; pass++) begin
      i_bright = '1;
      load(1'b0, 40'h00000012AF, '0, '0, '0, (pass == 0));
      repeat (FRAME + 1) step();
      for (int i = 0; i < FRAME; i++) begin
        step();
        n_checks++;
        if ({disp_seg_o, disp_an_o, o_frame} !== {exp_seg, exp_an, exp_frame}) begin
          n_fail++;
          $display("FAIL hex_model cyc=%0d: seg=%h an=%b frame=%b, expected seg=%h an=%b frame=%b",
                   cyc, disp_seg_o, disp_an_o, o_frame, exp_seg, exp_an, exp_frame);
        end
        if (disp_an_o !== '1) begin
          case (disp_an_o)
            5'b11110: want = 8'h8E;
            5'b11101: want = 8'h88;
            5'b11011: want = 8'hA4;
            5'b10111: want = 8'hF9;
            5'b01111: want = (pass == 0) ? 8'hxx : 8'hC0;
            default:  want = 8'hxx;
          endcase
          n_checks++;
          if (disp_seg_o !== want) begin
            n_fail++;
            $display("FAIL hex_digit lzs=%0d an=%b: seg=%h, expected %h", pass == 0, disp_an_o,
                     disp_seg_o, want);
          end
        end
      end
    end
  endtask

  task automatic test_raw();
    int pulses = 0;
    int last = -1;
    load(1'b1, 40'h007E55183C, 5'b10101, '0, '0, 1'b1);
    repeat (FRAME + 1) step();
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      n_checks++;
      if ({disp_seg_o, disp_an_o, o_frame} !== {exp_seg, exp_an, exp_frame}) begin
        n_fail++;
        $display("FAIL raw_model cyc=%0d: seg=%h an=%b frame=%b, expected seg=%h an=%b frame=%b",
                 cyc, disp_seg_o, disp_an_o, o_frame, exp_seg, exp_an, exp_frame);
      end
      if (disp_an_o === 5'b11011) begin
        n_checks++;
        if (disp_seg_o !== 8'h55) begin
          n_fail++;
          $display("FAIL raw_byte2: seg=%h, expected 55", disp_seg_o);
        end
      end
      if (o_frame === 1'b1) begin
        pulses++;
        if (last >= 0) begin
          n_checks++;
          if (cyc - last != FRAME) begin
            n_fail++;
            $display("FAIL frame_spacing: %0d clk, expected %0d", cyc - last, FRAME);
          end
        end
        last = cyc;
      end
    end
    n_checks++;
    if (pulses != 3) begin
      n_fail++;
      $display("FAIL frame_count: %0d pulses, expected 3", pulses);
    end
  endtask

  task automatic test_double_load();
    int seen_new = 0;
    for (int i = 0; i < FRAME && (cyc % FRAME) != 10; i++) step();
    load(1'b0, 40'h0000011111, '0, '0, '0, 1'b0);
    load(1'b0, '1, '0, '0, '0, 1'b0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      n_checks++;
      if ({disp_seg_o, disp_an_o, o_frame} !== {exp_seg, exp_an, exp_frame}) begin
        n_fail++;
        $display("FAIL dbl_model cyc=%0d: seg=%h an=%b frame=%b, expected seg=%h an=%b frame=%b",
                 cyc, disp_seg_o, disp_an_o, o_frame, exp_seg, exp_an, exp_frame);
      end
      n_checks++;
      if (disp_seg_o === 8'hF9) begin
        n_fail++;
        $display("FAIL dbl_first_shown cyc=%0d: seg=%h, expected never f9", cyc, disp_seg_o);
      end
      if (disp_seg_o === 8'h8E) seen_new++;
    end
    n_checks++;
    if (seen_new == 0) begin
      n_fail++;
      $display("FAIL dbl_second_shown: %0d cycles with 8e, expected > 0", seen_new);
    end
  endtask

  task automatic test_load_on_wrap();
    logic [7:0] want;
    for (int i = 0; i < FRAME && (cyc % FRAME) != FRAME - 1; i++) step();
    load(1'b0, '0, '0, '0, '0, 1'b0);
    for (int k = 1; k <= 2 * FRAME; k++) begin
      step();
      want = (k <= FRAME) ? 8'h8E : 8'hC0;
      n_checks++;
      if ({disp_seg_o, disp_an_o, o_frame} !== {exp_seg, exp_an, exp_frame}) begin
        n_fail++;
        $display("FAIL wrap_model cyc=%0d: seg=%h an=%b frame=%b, expected seg=%h an=%b frame=%b",
                 cyc, disp_seg_o, disp_an_o, o_frame, exp_seg, exp_an, exp_frame);
      end
      if (disp_an_o !== '1) begin
        n_checks++;
        if (disp_seg_o !== want) begin
          n_fail++;
          $display("FAIL wrap_load k=%0d: seg=%h, expected %h", k, disp_seg_o, want);
        end
      end
    end
  endtask

  task automatic test_pwm();
    int lit = 0;
    i_bright = '0;
    load(1'b0, 40'h0000088888, '0, '0, '0, 1'b0);
    repeat (FRAME + 1) step();
    for (int i = 0; i < FRAME; i++) begin
      step();
      n_checks++;
      if (disp_an_o !== '1 || disp_seg_o !== 8'hFF) begin
        n_fail++;
        $display("FAIL pwm_zero cyc=%0d: seg=%h an=%b, expected seg=ff an=%b",
                 cyc, disp_seg_o, disp_an_o, {N{1'b1}});
      end
    end
    i_bright = 4'd8;
    for (int i = 0; i < 400; i++) begin
      step();
      n_checks++;
      if ({disp_seg_o, disp_an_o, o_frame} !== {exp_seg, exp_an, exp_frame}) begin
        n_fail++;
        $display("FAIL pwm_model cyc=%0d: seg=%h an=%b frame=%b, expected seg=%h an=%b frame=%b",
                 cyc, disp_seg_o, disp_an_o, o_frame, exp_seg, exp_an, exp_frame);
      end
      if (disp_an_o !== '1) lit++;
    end
    n_checks++;
    if (lit != 200) begin
      n_fail++;
      $display("FAIL pwm_half: %0d lit cycles of 400, expected 200", lit);
    end
  endtask

  task automatic test_blink();
    int lit_on = 0;
    int lit_off = 0;
    bit msb;
    i_bright = '1;
    load(1'b0, 40'h0000088888, '0, '0, 5'b00010, 1'b0);
    repeat (FRAME + 1) step();
    for (int i = 0; i < 512; i++) begin
      step();
      msb = ((cyc - 1) % (1 << B)) >= (1 << (B - 1));
      n_checks++;
      if ({disp_seg_o, disp_an_o, o_frame} !== {exp_seg, exp_an, exp_frame}) begin
        n_fail++;
        $display("FAIL blink_model cyc=%0d: seg=%h an=%b frame=%b, expected seg=%h an=%b frame=%b",
                 cyc, disp_seg_o, disp_an_o, o_frame, exp_seg, exp_an, exp_frame);
      end
      if (disp_an_o === 5'b11101) begin
        if (msb) lit_on++;
        else lit_off++;
      end
    end
    n_checks++;
    if (lit_on != 0 || lit_off == 0) begin
      n_fail++;
      $display("FAIL blink_digit1: lit %0d with msb=1 and %0d with msb=0, expected 0 and > 0",
               lit_on, lit_off);
    end
  endtask

  task automatic test_reset_mid();
    bit lit_seen = 0;
    i_bright = '1;
    load(1'b0, 40'h0000012345, '0, '0, '0, 1'b0);
    repeat (FRAME + 1) step();
    for (int i = 0; i < FRAME && (cyc % FRAME) != 10; i++) step();
    load(1'b0, '0, '1, '0, '0, 1'b0);
    for (int i = 0; i < 16 && !lit_seen; i++) begin
      if (disp_an_o !== '1) lit_seen = 1;
      else step();
    end
    n_checks++;
    if (!lit_seen) begin
      n_fail++;
      $display("FAIL rst_mid_prelit: an=%b, expected a lit digit before reset", disp_an_o);
    end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({disp_seg_o, disp_an_o, o_frame} !== {8'hFF, {N{1'b1}}, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_async: seg=%h an=%b frame=%b, expected seg=ff an=%b frame=0",
               disp_seg_o, disp_an_o, o_frame, {N{1'b1}});
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      n_checks++;
      if ({disp_seg_o, disp_an_o, o_frame} !== {exp_seg, exp_an, exp_frame} || disp_an_o !== '1) begin
        n_fail++;
        $display("FAIL rst_mid_dark cyc=%0d: seg=%h an=%b frame=%b, expected seg=ff an=%b frame=%b",
                 cyc, disp_seg_o, disp_an_o, o_frame, {N{1'b1}}, exp_frame);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] r64;
    logic [8*N-1:0] d;
    int keep;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        r64 = {$urandom(), $urandom()};
        d = r64[8*N-1:0];
        if ($urandom_range(0, 1) == 1) begin
          keep = $urandom_range(0, N);
          for (int j = keep; j < N; j++) d[4*j +: 4] = 4'h0;
        end
        disp_mode = 1'($urandom_range(0, 1)); i_data = d;
        i_dp = N'($urandom()); i_blank_mask = N'($urandom() & $urandom() & $urandom());
        i_blink_mask = N'($urandom() & $urandom()); i_lzs = 1'($urandom_range(0, 1));
        i_load = 1'b1;
      end
      if ($urandom_range(0, 99) == 0) i_bright = P'($urandom());
      step();
      i_load = 1'b0;
      n_checks++;
      if ({disp_seg_o, disp_an_o, o_frame} !== {exp_seg, exp_an, exp_frame}) begin
        n_fail++;
        $display("FAIL rand_model cyc=%0d: seg=%h an=%b frame=%b, expected seg=%h an=%b frame=%b",
                 cyc, disp_seg_o, disp_an_o, o_frame, exp_seg, exp_an, exp_frame);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hex_lzs();
    test_raw();
    test_double_load();
    test_load_on_wrap();
    test_pwm();
    test_blink();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
